v_vram: RTL and testbench

Vector RAM responder: the memory-side end of the VRAM port driven by the vector memory unit (`vram_ren/wen/addr/mask/din` in, `vram_dout` back). It holds `DEPTH` words of `VLEN` bits and performs bit-masked writes and registered reads. It also runs a post-reset clear sweep and flags illegal or early accesses. It sits between the vector LSU and the simulation/top-level memory map at `BASE_ADDR`.

---
 rtl/v_vram_pkg.sv | 26 ++
 rtl/v_vram_if.sv | 25 ++
 rtl/v_vram_array.sv | 26 ++
 rtl/v_vram.sv | 101 ++++++++++
 tb/tb_v_vram.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/v_vram_pkg.sv
// Shared parameters, state encoding and write-port payload for the vector RAM.
package v_vram_pkg;

   localparam int unsigned VLEN   = 512;
   localparam int unsigned DEPTH  = 64;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned OFF_W  = $clog2(VLEN / 8);
   localparam int unsigned IDX_W  = $clog2(DEPTH);

   localparam logic [ADDR_W-1:0] BASE_ADDR = 32'h8100_0000;
   // Size of the mapped window in bytes.
   localparam logic [ADDR_W-1:0] SPAN      = ADDR_W'(DEPTH * (VLEN / 8));

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } vram_state_e;

   // One masked write into the storage array.
   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [VLEN-1:0]  mask;
      logic [VLEN-1:0]  data;
   } vram_wr_t;

endpackage

// File: rtl/v_vram_if.sv
// VRAM port between the vector LSU (master) and the RAM responder (slave).
interface v_vram_if;
   import v_vram_pkg::*;

   logic              vram_ren_i;
   logic              vram_wen_i;
   logic [ADDR_W-1:0] vram_addr_i;
   logic [VLEN-1:0]   vram_mask_i;
   logic [VLEN-1:0]   vram_din_i;
   logic [VLEN-1:0]   vram_dout_o;
   logic              vram_dvalid_o;
   logic              vram_err_o;
   logic              vram_ready_o;

   modport master (
      output vram_ren_i, vram_wen_i, vram_addr_i, vram_mask_i, vram_din_i,
      input  vram_dout_o, vram_dvalid_o, vram_err_o, vram_ready_o
   );

   modport slave (
      input  vram_ren_i, vram_wen_i, vram_addr_i, vram_mask_i, vram_din_i,
      output vram_dout_o, vram_dvalid_o, vram_err_o, vram_ready_o
   );

endinterface

// File: rtl/v_vram_array.sv
// DEPTH x VLEN storage: one bit-masked write port, one synchronous read port.
// The read samples the old word when both ports hit the same index.
module v_vram_array
   import v_vram_pkg::*;
(
   input  logic             clk,
   input  logic             we,
   input  vram_wr_t         wr,
   input  logic             re,
   input  logic [IDX_W-1:0] ridx,
   output logic [VLEN-1:0]  rdata
);

   logic [VLEN-1:0] mem [DEPTH];

   // Masked write and held synchronous read; no reset on storage.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr.idx] <= (mem[wr.idx] & ~wr.mask) | (wr.data & wr.mask);
      end
      if (re) begin
         rdata <= mem[ridx];
      end
   end

endmodule

// File: rtl/v_vram.sv
// Vector RAM responder: clear sweep after reset, address decode,
// legality checks and the read-result/status registers.
module v_vram
   import v_vram_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   v_vram_if.slave bus
);

   vram_state_e       state;
   logic [IDX_W-1:0]  ptr;
   logic              ready_q;
   logic              dvalid_q;
   logic              err_q;
   logic              have_data_q;

   logic [ADDR_W-1:0] off;
   logic [IDX_W-1:0]  idx;
   logic              aligned;
   logic              in_range;
   logic              req;
   logic              legal;
   logic              rd_en;
   logic              wr_en;
   vram_wr_t          wr;
   logic [VLEN-1:0]   rdata;

   // Address decode, legality and write-port steering (sweep owns the port in INIT).
   always_comb begin
      off      = bus.vram_addr_i - BASE_ADDR;
      aligned  = (off[OFF_W-1:0] == '0);
      in_range = (off < SPAN);
      idx      = off[OFF_W +: IDX_W];
      req      = bus.vram_ren_i | bus.vram_wen_i;
      legal    = ready_q & aligned & in_range;
      rd_en    = bus.vram_ren_i & legal;
      wr_en    = 1'b0;
      wr.idx   = idx;
      wr.mask  = bus.vram_mask_i;
      wr.data  = bus.vram_din_i;
      if (state == ST_INIT) begin
         wr_en   = 1'b1;
         wr.idx  = ptr;
         wr.mask = '1;
         wr.data = '0;
      end else begin
         wr_en   = bus.vram_wen_i & legal;
      end
   end

   v_vram_array u_array (
      .clk   (clk),
      .we    (wr_en),
      .wr    (wr),
      .re    (rd_en),
      .ridx  (idx),
      .rdata (rdata)
   );

   // Clear-sweep FSM plus registered status pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_INIT;
         ptr         <= '0;
         ready_q     <= 1'b0;
         dvalid_q    <= 1'b0;
         err_q       <= 1'b0;
         have_data_q <= 1'b0;
      end else begin
         dvalid_q <= rd_en;
         err_q    <= req & ~legal;
         if (rd_en) begin
            have_data_q <= 1'b1;
         end
         case (state)
            ST_INIT: begin
               ptr <= ptr + IDX_W'(1);
               if (ptr == IDX_W'(DEPTH - 1)) begin
                  state   <= ST_IDLE;
                  ready_q <= 1'b1;
               end
            end
            ST_IDLE: begin
               ready_q <= 1'b1;
            end
            default: begin
               state <= ST_INIT;
               ptr   <= '0;
            end
         endcase
      end
   end

   // Read data is zero until the first accepted read after reset, then holds.
   assign bus.vram_dout_o   = have_data_q ? rdata : '0;
   assign bus.vram_dvalid_o = dvalid_q;
   assign bus.vram_err_o    = err_q;
   assign bus.vram_ready_o  = ready_q;

endmodule

// File: tb/tb_v_vram.sv
// Self-checking bench for v_vram against a word-array reference model.
module tb_v_vram;
   import v_vram_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [VLEN-1:0] model [DEPTH];
   logic [VLEN-1:0] exp_dout;
   logic            mready;

   v_vram_if bus ();

   v_vram dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [VLEN-1:0] rnd_word();
      logic [VLEN-1:0] r;
      for (int i = 0; i < VLEN / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic idle();
      bus.vram_ren_i  = 1'b0;
      bus.vram_wen_i  = 1'b0;
      bus.vram_addr_i = '0;
      bus.vram_mask_i = '0;
      bus.vram_din_i  = '0;
   endtask

   // One request cycle: drive, take one edge, check against the model, update model.
   task automatic req(input string tag, input logic r, input logic w, input logic [31:0] a,
                      input logic [VLEN-1:0] m, input logic [VLEN-1:0] d);
      longint unsigned off;
      int unsigned     widx;
      logic            legal;
      logic            ev;
      logic            ee;
      off   = (longint'(a) - longint'(BASE_ADDR)) & 64'hFFFF_FFFF;
      legal = mready && (off % (VLEN / 8) == 0) && (off < DEPTH * (VLEN / 8));
      widx  = int'(off / (VLEN / 8));
      ev    = r && legal;
      ee    = (r || w) && !legal;
      if (ev) exp_dout = model[widx];
      bus.vram_ren_i  = r;
      bus.vram_wen_i  = w;
      bus.vram_addr_i = a;
      bus.vram_mask_i = m;
      bus.vram_din_i  = d;
      @(posedge clk);
      #1;
      chk({tag, ".dvalid"}, VLEN'(bus.vram_dvalid_o), VLEN'(ev));
      chk({tag, ".err"},    VLEN'(bus.vram_err_o),    VLEN'(ee));
      chk({tag, ".dout"},   bus.vram_dout_o,          exp_dout);
      if (w && legal) model[widx] = (model[widx] & ~m) | (d & m);
   endtask

   // Release reset and count edges until ready; optionally poke a write in cycle 10.
   task automatic wait_ready(input string tag, input logic poke);
      int n;
      logic got;
      @(posedge clk);
      #1;
      rst = 1'b1;
      n   = 0;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         if (poke && n == 9) begin
            bus.vram_wen_i  = 1'b1;
            bus.vram_addr_i = BASE_ADDR + 32'h100;
            bus.vram_mask_i = '1;
            bus.vram_din_i  = '1;
         end
         @(posedge clk);
         #1;
         n++;
         if (poke && n == 10) begin
            chk({tag, ".init_err"},    VLEN'(bus.vram_err_o),    VLEN'(1));
            chk({tag, ".init_dvalid"}, VLEN'(bus.vram_dvalid_o), VLEN'(0));
            idle();
         end
         if (bus.vram_ready_o === 1'b1) got = 1'b1;
      end
      chk({tag, ".ready_cycles"}, VLEN'(n), VLEN'(DEPTH));
      for (int k = 0; k < DEPTH; k++) model[k] = '0;
      mready = 1'b1;
   endtask

   initial begin
      logic [VLEN-1:0] a5;
      logic [VLEN-1:0] m8;
      checks   = 0;
      errors   = 0;
      mready   = 1'b0;
      exp_dout = '0;
      for (int k = 0; k < DEPTH; k++) model[k] = '0;
      idle();
      rst = 1'b0;
      #23;
      chk("reset.dout",   bus.vram_dout_o,          '0);
      chk("reset.dvalid", VLEN'(bus.vram_dvalid_o), '0);
      chk("reset.err",    VLEN'(bus.vram_err_o),    '0);
      chk("reset.ready",  VLEN'(bus.vram_ready_o),  '0);

      wait_ready("init1", 1'b1);

      req("rd_first", 1'b1, 1'b0, 32'h8100_0000, '0, '0);
      req("rd_last",  1'b1, 1'b0, 32'h8100_0FC0, '0, '0);
      req("rd_poked", 1'b1, 1'b0, 32'h8100_0100, '0, '0);

      m8 = '0;
      m8[7:0] = 8'hFF;
      req("wr_ones",  1'b0, 1'b1, 32'h8100_0040, '1, '1);
      req("wr_low0",  1'b0, 1'b1, 32'h8100_0040, m8, '0);
      req("wr_mask0", 1'b0, 1'b1, 32'h8100_0040, '0, '0);
      req("rd_mask",  1'b1, 1'b0, 32'h8100_0040, '0, '0);
      chk("rd_mask.bits", bus.vram_dout_o, ~m8);

      a5 = {(VLEN / 8){8'hA5}};
      req("rw_same",  1'b1, 1'b1, 32'h8100_0080, '1, a5);
      chk("rw_same.old", bus.vram_dout_o, '0);
      req("rw_after", 1'b1, 1'b0, 32'h8100_0080, '0, '0);
      chk("rw_after.new", bus.vram_dout_o, a5);

      req("ill_misal", 1'b1, 1'b0, 32'h8100_0004, '0, '0);
      req("ill_past",  1'b1, 1'b0, 32'h8100_1000, '0, '0);
      req("ill_below", 1'b1, 1'b0, 32'h80FF_FFC0, '0, '0);
      req("ill_wr",    1'b0, 1'b1, 32'h8100_0044, '1, '1);
      req("rd_keep",   1'b1, 1'b0, 32'h8100_0040, '0, '0);
      req("rd_keep2",  1'b1, 1'b0, 32'h8100_0080, '0, '0);

      // Randomized mix of legal and illegal traffic, back-to-back.
      for (int t = 0; t < 400; t++) begin
         logic [31:0] a;
         logic        r;
         logic        w;
         int unsigned sel;
         sel = $urandom_range(0, 9);
         a   = BASE_ADDR + 32'($urandom_range(0, DEPTH - 1) * (VLEN / 8));
         if (sel == 0) a = a + 32'($urandom_range(1, VLEN / 8 - 1));
         if (sel == 1) a = BASE_ADDR + 32'($urandom_range(DEPTH, 4 * DEPTH) * (VLEN / 8));
         if (sel == 2) a = BASE_ADDR - 32'($urandom_range(1, 8) * (VLEN / 8));
         r = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         req("rand", r, w, a, rnd_word(), rnd_word());
      end

      // Reset lands in the cycle of an outstanding read; nothing must come back.
      req("pre_rst", 1'b1, 1'b0, 32'h8100_0080, '0, '0);
      bus.vram_ren_i  = 1'b1;
      bus.vram_addr_i = 32'h8100_0080;
      #4;
      rst = 1'b0;
      #1;
      chk("midrst.dvalid", VLEN'(bus.vram_dvalid_o), '0);
      chk("midrst.dout",   bus.vram_dout_o,          '0);
      chk("midrst.ready",  VLEN'(bus.vram_ready_o),  '0);
      idle();
      mready   = 1'b0;
      exp_dout = '0;
      @(posedge clk);
      #1;
      chk("midrst.hold_dvalid", VLEN'(bus.vram_dvalid_o), '0);
      wait_ready("init2", 1'b0);
      req("post_rd80", 1'b1, 1'b0, 32'h8100_0080, '0, '0);
      req("post_rd40", 1'b1, 1'b0, 32'h8100_0040, '0, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
